// File: rtl/qam_pkg.sv
// Shared constants and the Gray-coded level map for the 16-QAM transmit path.
package qam_pkg;

    localparam int CARRIER_MSB = 31;
    localparam int CARRIER_LSB = 16;
    localparam int CARRIER_W   = CARRIER_MSB - CARRIER_LSB + 1;
    localparam int SUM_W       = 19;
    localparam int OUT_SHIFT   = 3;
    localparam int OUT_W       = 16;
    localparam int LVL_W       = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mix_state_e;

    // Gray map shared by I and Q: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3.
    function automatic logic signed [LVL_W-1:0] qam_level(input logic [1:0] bits);
        logic signed [LVL_W-1:0] lvl;
        case (bits)
            2'b00:   lvl = 3'sb101;
            2'b01:   lvl = 3'sb111;
            2'b11:   lvl = 3'sb001;
            2'b10:   lvl = 3'sb011;
            default: lvl = 3'sb000;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/qam16_mixer_if.sv
// Symbol handshake and modulated-sample output bundle of qam16_mixer.
interface qam16_mixer_if;

    logic        sym_valid;
    logic        sym_ready;
    logic [3:0]  sym_data;
    logic        out_valid;
    logic [15:0] out_data;

    modport master (
        output sym_valid,
        output sym_data,
        input  sym_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  sym_valid,
        input  sym_data,
        output sym_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/qam_iq_mult.sv
// Three-stage I*cos - Q*sin pipeline, advanced by sample_en and its delayed copies.
// Optional QAM16_MIXER_ROUND_EN selects round-half-up instead of truncation at s3.
module qam_iq_mult
    import qam_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [CARRIER_W-1:0] ci,
    input  logic signed [CARRIER_W-1:0] cq,
    input  logic signed [LVL_W-1:0]     li,
    input  logic signed [LVL_W-1:0]     lq,
    output logic                        out_valid,
    output logic signed [OUT_W-1:0]     out_data
);

    logic                        v1_r, v2_r, v3_r;
    logic signed [CARRIER_W-1:0] ci_r, cq_r;
    logic signed [LVL_W-1:0]     li_r, lq_r;
    logic signed [SUM_W-1:0]     pi_r, pq_r;
    logic signed [OUT_W-1:0]     out_r;

    logic signed [SUM_W-1:0]     ci_x_s, cq_x_s, li_x_s, lq_x_s;
    logic signed [SUM_W-1:0]     pi_s, pq_s, sum_s, rnd_s;

    // Sign-extended products, the difference and the output scaling.
    always_comb begin
        ci_x_s = {{(SUM_W - CARRIER_W){ci_r[CARRIER_W-1]}}, ci_r};
        cq_x_s = {{(SUM_W - CARRIER_W){cq_r[CARRIER_W-1]}}, cq_r};
        li_x_s = {{(SUM_W - LVL_W){li_r[LVL_W-1]}}, li_r};
        lq_x_s = {{(SUM_W - LVL_W){lq_r[LVL_W-1]}}, lq_r};
        pi_s   = ci_x_s * li_x_s;
        pq_s   = cq_x_s * lq_x_s;
        sum_s  = pi_r - pq_r;
`ifdef QAM16_MIXER_ROUND_EN
        rnd_s  = sum_s + 19'sd4;
`else
        rnd_s  = sum_s;
`endif
    end

    // Pipeline registers; each stage only loads when its valid copy is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r  <= 1'b0;
            v2_r  <= 1'b0;
            v3_r  <= 1'b0;
            ci_r  <= '0;
            cq_r  <= '0;
            li_r  <= '0;
            lq_r  <= '0;
            pi_r  <= '0;
            pq_r  <= '0;
            out_r <= '0;
        end else begin
            v1_r <= en;
            v2_r <= v1_r;
            v3_r <= v2_r;
            if (en) begin
                ci_r <= ci;
                cq_r <= cq;
                li_r <= li;
                lq_r <= lq;
            end
            if (v1_r) begin
                pi_r <= pi_s;
                pq_r <= pq_s;
            end
            if (v2_r) begin
                out_r <= rnd_s[SUM_W-1:OUT_SHIFT];
            end
        end
    end

    assign out_valid = v3_r;
    assign out_data  = out_r;

endmodule

// File: rtl/qam16_mixer.sv
// 16-QAM modulator: accepts symbols, holds each for SAMPLES_PER_SYM carrier samples.
// Build option QAM16_MIXER_ROUND_EN enables round-half-up output scaling.
module qam16_mixer
    import qam_pkg::*;
#(
    parameter int SAMPLES_PER_SYM = 64
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [31:0]         carrier_i,
    input  logic [31:0]         carrier_q,
    qam16_mixer_if.slave        sym_if,
    output logic                underrun
);

    localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYM - 1);

    mix_state_e              state_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [LVL_W-1:0] li_r, lq_r;
    logic                    underrun_r;
    logic                    sym_ready_s;
    logic                    xfer_s;
    logic                    out_valid_s;
    logic signed [OUT_W-1:0] out_data_s;
    logic                    unused_carrier_lsb_s;

    // Ready is combinational: open in IDLE, else only on the last sample of a period.
    always_comb begin
        sym_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: sym_ready_s = 1'b1;
            ST_RUN:  sym_ready_s = sample_en && (cnt_r == LAST_CNT);
            default: sym_ready_s = 1'b0;
        endcase
        xfer_s = sym_if.sym_valid & sym_ready_s;
    end

    // Symbol FSM, sample counter, level registers and sticky underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            li_r       <= 3'sb000;
            lq_r       <= 3'sb000;
            underrun_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        li_r    <= qam_level(sym_if.sym_data[3:2]);
                        lq_r    <= qam_level(sym_if.sym_data[1:0]);
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sample_en) begin
                        if (cnt_r == LAST_CNT) begin
                            cnt_r <= '0;
                            if (xfer_s) begin
                                li_r <= qam_level(sym_if.sym_data[3:2]);
                                lq_r <= qam_level(sym_if.sym_data[1:0]);
                            end else begin
                                li_r       <= 3'sb000;
                                lq_r       <= 3'sb000;
                                underrun_r <= 1'b1;
                                state_r    <= ST_IDLE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    qam_iq_mult u_iq_mult (
        .clk       (clk),
        .rst       (rst),
        .en        (sample_en),
        .ci        (carrier_i[CARRIER_MSB:CARRIER_LSB]),
        .cq        (carrier_q[CARRIER_MSB:CARRIER_LSB]),
        .li        (li_r),
        .lq        (lq_r),
        .out_valid (out_valid_s),
        .out_data  (out_data_s)
    );

    assign unused_carrier_lsb_s = ^{carrier_i[CARRIER_LSB-1:0], carrier_q[CARRIER_LSB-1:0]};

    assign sym_if.sym_ready = sym_ready_s;
    assign sym_if.out_valid = out_valid_s;
    assign sym_if.out_data  = out_data_s;
    assign underrun         = underrun_r;

endmodule
